// File: rtl/color_issue_arbiter.sv
// Round-robin issue scheduler sharing one memory request port among COLORS requesters.
// Each color owns MIN_DEPTH reserved in-flight slots; HEAD_ROOM further slots are shared.
// Responses return credits by tag; a response for an idle color raises a sticky error.
module color_issue_arbiter #(
  parameter int unsigned COLORS    = 4,
  parameter int unsigned MIN_DEPTH = 32,
  parameter int unsigned MAX_DEPTH = 512,
  localparam int unsigned TAG_W    = $clog2(COLORS),
  localparam int unsigned CNT_W    = $clog2(MAX_DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [COLORS-1:0] req,
  output logic [COLORS-1:0] grant,
  output logic              mem_req_valid,
  output logic [TAG_W-1:0]  mem_req_tag,
  input  logic              mem_req_ready,
  input  logic              rsp_valid,
  input  logic [TAG_W-1:0]  rsp_tag,
  output logic [CNT_W-1:0]  in_flight,
  output logic              err
);

  localparam int unsigned HEAD_ROOM = MAX_DEPTH - COLORS * MIN_DEPTH;
  localparam logic [CNT_W-1:0] MinD     = CNT_W'(MIN_DEPTH);
  localparam logic [CNT_W-1:0] HeadRoom = CNT_W'(HEAD_ROOM);
  localparam logic [CNT_W-1:0] One      = CNT_W'(1);

  // Credit state: per-color counts plus incrementally maintained shared-pool usage.
  logic [CNT_W-1:0] r_count [COLORS];
  logic [CNT_W-1:0] r_shared_used;
  logic [CNT_W-1:0] r_in_flight;
  logic [TAG_W-1:0] r_rr;
  logic             r_valid;
  logic [TAG_W-1:0] r_tag;
  logic             r_err;

  logic [CNT_W-1:0]  w_count_d [COLORS];
  logic [CNT_W-1:0]  w_shared_d;
  logic [CNT_W-1:0]  w_in_flight_d;
  logic [COLORS-1:0] w_eligible;
  logic              w_load;
  logic              w_any;
  logic [TAG_W-1:0]  w_pick;
  logic [TAG_W-1:0]  w_scan_idx;
  logic              w_do_grant;
  logic              w_rsp_ok;
  logic              w_same;

  // A color may issue if it is under its reservation or the shared pool has room.
  always_comb begin
    w_eligible = '0;
    for (int c = 0; c < COLORS; c++) begin
      w_eligible[c] = req[c] && ((r_count[c] < MinD) || (r_shared_used < HeadRoom));
    end
  end

  assign w_load = !r_valid || mem_req_ready;

  // Scan from the color after the rr pointer; the pointer itself is checked last.
  always_comb begin
    w_any      = 1'b0;
    w_pick     = '0;
    w_scan_idx = '0;
    for (int i = 1; i <= COLORS; i++) begin
      w_scan_idx = r_rr + TAG_W'(i);
      if (!w_any && w_eligible[w_scan_idx]) begin
        w_any  = 1'b1;
        w_pick = w_scan_idx;
      end
    end
  end

  assign w_do_grant = w_load && w_any && !rst;
  assign grant      = w_do_grant ? (COLORS'(1) << w_pick) : '0;

  // Credit bookkeeping; a same-color grant and response cancel out completely.
  always_comb begin
    for (int c = 0; c < COLORS; c++) begin
      w_count_d[c] = r_count[c];
    end
    w_shared_d    = r_shared_used;
    w_in_flight_d = r_in_flight;
    w_rsp_ok      = rsp_valid && (r_count[rsp_tag] != '0);
    w_same        = w_do_grant && w_rsp_ok && (w_pick == rsp_tag);
    if (!w_same) begin
      if (w_do_grant) begin
        w_count_d[w_pick] = r_count[w_pick] + One;
        w_in_flight_d     = w_in_flight_d + One;
        if (r_count[w_pick] >= MinD) begin
          w_shared_d = w_shared_d + One;
        end
      end
      if (w_rsp_ok) begin
        w_count_d[rsp_tag] = r_count[rsp_tag] - One;
        w_in_flight_d      = w_in_flight_d - One;
        if (r_count[rsp_tag] > MinD) begin
          w_shared_d = w_shared_d - One;
        end
      end
    end
  end

  // Credit registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int c = 0; c < COLORS; c++) begin
        r_count[c] <= '0;
      end
      r_shared_used <= '0;
      r_in_flight   <= '0;
    end else begin
      for (int c = 0; c < COLORS; c++) begin
        r_count[c] <= w_count_d[c];
      end
      r_shared_used <= w_shared_d;
      r_in_flight   <= w_in_flight_d;
    end
  end

  // Issue register, rr pointer and sticky error; the register only changes when load is set.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_tag   <= '0;
      r_rr    <= TAG_W'(COLORS - 1);
      r_err   <= 1'b0;
    end else begin
      if (w_load) begin
        if (w_any) begin
          r_valid <= 1'b1;
          r_tag   <= w_pick;
          r_rr    <= w_pick;
        end else begin
          r_valid <= 1'b0;
        end
      end
      if (rsp_valid && !w_rsp_ok) begin
        r_err <= 1'b1;
      end
    end
  end

  assign mem_req_valid = r_valid;
  assign mem_req_tag   = r_tag;
  assign in_flight     = r_in_flight;
  assign err           = r_err;

  // Capacity invariants that hold by construction of the eligibility rule.
  a_in_flight_bound: assert property (@(posedge clk) disable iff (rst)
    r_in_flight <= CNT_W'(MAX_DEPTH));
  a_shared_bound: assert property (@(posedge clk) disable iff (rst)
    r_shared_used <= HeadRoom);

endmodule

// File: tb/tb_color_issue_arbiter.sv
// Self-checking bench: directed scenarios with literal expectations plus a randomized run,
// all cross-checked every cycle against a credit-level behavioural model.
module tb_color_issue_arbiter;

  localparam int COLORS = 4;
  localparam int MIN_D  = 32;
  localparam int MAX_D  = 512;
  localparam int HEAD   = MAX_D - COLORS * MIN_D;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] req = '0;
  logic [3:0] grant;
  logic       mem_req_valid;
  logic [1:0] mem_req_tag;
  logic       mem_req_ready = 1'b1;
  logic       rsp_valid = 1'b0;
  logic [1:0] rsp_tag = '0;
  logic [9:0] in_flight;
  logic       err;

  int n_checks = 0;
  int n_err    = 0;

  // Behavioural model: counts per color, issue register contents, rr pointer, error flag.
  int m_cnt [COLORS];
  int m_valid, m_tag, m_rr, m_err;
  bit m_known = 1'b0;
  int gcnt [COLORS];

  color_issue_arbiter dut (
    .clk           (clk),
    .rst           (rst),
    .req           (req),
    .grant         (grant),
    .mem_req_valid (mem_req_valid),
    .mem_req_tag   (mem_req_tag),
    .mem_req_ready (mem_req_ready),
    .rsp_valid     (rsp_valid),
    .rsp_tag       (rsp_tag),
    .in_flight     (in_flight),
    .err           (err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req = '0;
    rsp_valid = 1'b0;
    mem_req_ready = 1'b1;
    cyc(1);
    rst = 1'b0;
  endtask

  task automatic zero_gcnt();
    for (int c = 0; c < COLORS; c++) gcnt[c] = 0;
  endtask

  // Compare process: check registered outputs, predict grant, then advance the model.
  always @(negedge clk) begin
    int shared, sum, load, gc, old_t;
    int exp_grant;
    for (int c = 0; c < COLORS; c++) gcnt[c] += int'(grant[c]);
    exp_grant = 0;
    gc = -1;
    if (m_known) begin
      sum = 0;
      shared = 0;
      for (int c = 0; c < COLORS; c++) begin
        sum += m_cnt[c];
        if (m_cnt[c] > MIN_D) shared += m_cnt[c] - MIN_D;
      end
      chk("model_valid", int'(mem_req_valid), m_valid);
      if (m_valid != 0) chk("model_tag", int'(mem_req_tag), m_tag);
      chk("model_in_flight", int'(in_flight), sum);
      chk("model_err", int'(err), m_err);
      load = (m_valid == 0 || mem_req_ready) ? 1 : 0;
      if (!rst && load != 0) begin
        for (int i = 1; i <= COLORS; i++) begin
          int c;
          c = (m_rr + i) % COLORS;
          if (gc < 0 && req[c] && (m_cnt[c] < MIN_D || shared < HEAD)) gc = c;
        end
      end
      if (gc >= 0) exp_grant = 1 << gc;
      chk("model_grant", int'(grant), exp_grant);
    end
    if (rst) begin
      for (int c = 0; c < COLORS; c++) m_cnt[c] = 0;
      m_valid = 0; m_tag = 0; m_rr = COLORS - 1; m_err = 0;
      m_known = 1'b1;
    end else if (m_known) begin
      old_t = m_cnt[rsp_tag];
      if (load != 0) begin
        if (gc >= 0) begin
          m_valid = 1; m_tag = gc; m_rr = gc;
          m_cnt[gc]++;
        end else begin
          m_valid = 0;
        end
      end
      if (rsp_valid) begin
        if (old_t > 0) m_cnt[rsp_tag]--;
        else m_err = 1;
      end
    end
  end

  initial begin
    int tot;
    zero_gcnt();
    do_reset();
    @(negedge clk);
    chk("reset_valid", int'(mem_req_valid), 0);
    chk("reset_tag", int'(mem_req_tag), 0);
    chk("reset_in_flight", int'(in_flight), 0);
    chk("reset_err", int'(err), 0);
    chk("reset_grant", int'(grant), 0);
    @(posedge clk); #1;

    // 1: all colors requesting rotate 0,1,2,3,...
    req = 4'b1111;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      chk("rr_grant", int'(grant), 1 << (k % 4));
      @(posedge clk); #1;
    end

    // 2: lone color 1 fills reservation plus the whole shared pool.
    do_reset();
    zero_gcnt();
    req = 4'b0010;
    cyc(450);
    @(negedge clk);
    chk("solo_grants", gcnt[1], MIN_D + HEAD);
    chk("solo_in_flight", int'(in_flight), 416);
    chk("solo_valid", int'(mem_req_valid), 0);
    chk("solo_grant_idle", int'(grant), 0);
    @(posedge clk); #1;

    // 3: color 2 still gets exactly its reservation.
    zero_gcnt();
    req = 4'b0110;
    cyc(60);
    @(negedge clk);
    chk("resv_grants_c2", gcnt[2], 32);
    chk("resv_grants_c1", gcnt[1], 0);
    chk("resv_in_flight", int'(in_flight), 448);
    @(posedge clk); #1;

    // 4: one freed shared slot yields exactly one more grant.
    zero_gcnt();
    rsp_valid = 1'b1; rsp_tag = 2'd1;
    cyc(1);
    rsp_valid = 1'b0;
    cyc(10);
    @(negedge clk);
    tot = 0;
    for (int c = 0; c < COLORS; c++) tot += gcnt[c];
    chk("freed_slot_grants", tot, 1);
    chk("freed_slot_in_flight", int'(in_flight), 448);
    @(posedge clk); #1;

    // 5: held request under backpressure.
    do_reset();
    req = 4'b1111;
    cyc(2);
    mem_req_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("hold_valid", int'(mem_req_valid), 1);
      chk("hold_tag", int'(mem_req_tag), 1);
      chk("hold_grant", int'(grant), 0);
      @(posedge clk); #1;
    end
    mem_req_ready = 1'b1;
    @(negedge clk);
    chk("hold_release_grant", int'(grant), 4'b0100);
    @(posedge clk); #1;

    // 6: same-color grant and response cancel; stray response sets err.
    do_reset();
    req = 4'b0001;
    cyc(5);
    rsp_valid = 1'b1; rsp_tag = 2'd0;
    cyc(1);
    req = 4'b0000; rsp_tag = 2'd3;
    cyc(1);
    rsp_valid = 1'b0;
    @(negedge clk);
    chk("cancel_in_flight", int'(in_flight), 5);
    chk("stray_rsp_err", int'(err), 1);
    @(posedge clk); #1;

    // 7: reset mid-operation clears everything, color 0 wins first.
    req = 4'b1111;
    cyc(2);
    rst = 1'b1;
    cyc(1);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_mid_valid", int'(mem_req_valid), 0);
    chk("rst_mid_in_flight", int'(in_flight), 0);
    chk("rst_mid_err", int'(err), 0);
    chk("rst_mid_grant", int'(grant), 4'b0001);
    @(posedge clk); #1;

    // Randomized traffic, checked by the model every cycle.
    for (int k = 0; k < 3000; k++) begin
      req           = 4'($urandom);
      mem_req_ready = ($urandom_range(0, 3) != 0);
      rsp_valid     = ($urandom_range(0, 1) != 0);
      rsp_tag       = 2'($urandom_range(0, 3));
      rst           = ($urandom_range(0, 499) == 0);
      cyc(1);
    end
    rst = 1'b0;
    cyc(2);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
